irq_flag_unit: RTL

Interrupt flag (IF) unit directly upstream of the SM83 core: it latches interrupt requests from the VBlank, STAT, Timer, Serial and Joypad sources, drives the core's `CPU_IRQ_TRIG[7:0]` pending vector, and clears individual bits on `CPU_IRQ_ACK[7:0]`. It also exposes IF as the memory-mapped register at 0xFF0F on the core's address and data bus. When `IRQ_WAKE_EN` is defined, it additionally generates the core's STOP-mode `WAKE` input.

---
 rtl/irq_pkg.sv | 46 ++++
 rtl/irq_edge_detect.sv | 49 ++++
 rtl/irq_flag_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants and helpers for the interrupt flag (IF) unit that sits in
// front of the SM83 core.
//
// Contents:
//   IRQ_VBL .. IRQ_JOYP : bit positions of each source inside IF / CPU_IRQ_TRIG
//   IRQ_IF_ADDR         : bus address of the IF register (0xFF0F)
//   IRQ_NUM_SRC         : number of implemented IF bits
//   IRQ_IF_W            : physical width of the IF register
//   IRQ_SYNC_RST        : reset value of the joypad synchronizer flops
//   irq_vec_t           : one bit per interrupt source
//   irq_impl_mask()     : mask of implemented IF bits for a given source count
// -----------------------------------------------------------------------------
package irq_pkg;

  // Bit positions inside IF and the pending vector.
  localparam int IRQ_VBL    = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYP   = 4;

  // Register map and sizing.
  localparam logic [15:0] IRQ_IF_ADDR = 16'hFF0F;
  localparam int unsigned IRQ_NUM_SRC = 5;
  localparam int unsigned IRQ_IF_W    = 5;

  // Joypad lines are active-low, so the idle (no key) value is all ones.
  localparam logic [3:0] IRQ_SYNC_RST = 4'hF;

  typedef logic [IRQ_IF_W-1:0] irq_vec_t;

  // Mask with a 1 for every implemented IF bit (bits below numSrc).
  function automatic irq_vec_t irq_impl_mask(input int unsigned numSrc);
    irq_vec_t mask;
    mask = '0;
    for (int unsigned i = 0; i < IRQ_IF_W; i++) begin
      if (i < numSrc) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// -----------------------------------------------------------------------------
// irq_edge_detect
// Registers the previous value of a bus of signals and reports, per bit, a
// single-cycle pulse when the bit changes in the selected direction. The edge
// output is combinational from the current input and the stored previous
// value, so it adds no latency beyond the one register.
//
// Parameters:
//   WIDTH   : number of bits watched
//   RST_VAL : value of the previous-value register while in reset; choose the
//             idle level of the input so release of reset creates no edge
//   RISING  : 1 = detect 0->1, 0 = detect 1->0
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   sig_i   : signals to watch (must be synchronous to clk_i)
//   edge_o  : per-bit edge pulse
// -----------------------------------------------------------------------------
module irq_edge_detect #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter bit                    RISING  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= sig_i;
    end
  end

  generate
    if (RISING) begin : g_rise
      assign edge_o = sig_i & ~prev_q;
    end else begin : g_fall
      assign edge_o = ~sig_i & prev_q;
    end
  endgenerate

endmodule

// File: rtl/irq_flag_unit.sv
// -----------------------------------------------------------------------------
// irq_flag_unit
// Interrupt flag (IF) register for the SM83 core. Latches edges of the VBlank,
// STAT, Timer, Serial and Joypad requests into IF, presents IF to the core as
// the pending vector, clears bits on acknowledge, and maps IF onto the core
// bus at IF_ADDR (0xFF0F).
//
// Optional feature macro: IRQ_WAKE_EN
//   defined   : WAKE is a registered "any key held" flag for STOP-mode wake
//   undefined : WAKE is tied low and its flop is not built
//
// Parameters:
//   NUM_SRC : implemented IF bits (1..5); higher bits read as 1, never pend
//   IF_ADDR : bus address of IF
//
// Ports:
//   CLK          : system clock, rising edge
//   nRESET       : asynchronous active-low reset
//   REQ_VBL      : VBlank request level (synchronous)
//   REQ_STAT     : STAT request level (synchronous)
//   REQ_TIMER    : timer overflow request level (synchronous)
//   REQ_SERIAL   : serial complete request level (synchronous)
//   nJOYP[3:0]   : joypad matrix lines, active low, asynchronous
//   A[15:0]      : core address bus
//   D_IN[7:0]    : core write data
//   D_OUT[7:0]   : read data (0 when not driving)
//   D_OE         : read-drive enable
//   RD / WR      : core read / write strobes
//   MMIO_REQ     : address is in 0xFExx / 0xFFxx
//   CPU_IRQ_TRIG : pending vector to the core
//   CPU_IRQ_ACK  : acknowledge from the core, one bit per source
//   WAKE         : STOP-mode wake to the core
// -----------------------------------------------------------------------------
module irq_flag_unit
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = IRQ_NUM_SRC,
  parameter logic [15:0] IF_ADDR = IRQ_IF_ADDR
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        REQ_VBL,
  input  logic        REQ_STAT,
  input  logic        REQ_TIMER,
  input  logic        REQ_SERIAL,
  input  logic [3:0]  nJOYP,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic        RD,
  input  logic        WR,
  input  logic        MMIO_REQ,
  output logic [7:0]  CPU_IRQ_TRIG,
  input  logic [7:0]  CPU_IRQ_ACK,
  output logic        WAKE
);

  localparam irq_vec_t IMPL_MASK = irq_impl_mask(NUM_SRC);

  irq_vec_t   if_q;
  irq_vec_t   if_d;
  irq_vec_t   rise;
  logic [3:0] syncReq;
  logic [3:0] syncRise;
  logic [3:0] joySync1_q;
  logic [3:0] joySync2_q;
  logic       joyAllHi;
  logic       joyFall;
  logic       regSel;
  logic       unusedBits;

  // Upper ack and write-data bits have no IF storage behind them.
  assign unusedBits = ^{CPU_IRQ_ACK[7:5], D_IN[7:5]};

  // ---------------------------------------------------------------------------
  // Synchronous sources: one rising-edge detector for all four.
  // ---------------------------------------------------------------------------
  always_comb begin
    syncReq             = '0;
    syncReq[IRQ_VBL]    = REQ_VBL;
    syncReq[IRQ_STAT]   = REQ_STAT;
    syncReq[IRQ_TIMER]  = REQ_TIMER;
    syncReq[IRQ_SERIAL] = REQ_SERIAL;
  end

  irq_edge_detect #(
    .WIDTH   (4),
    .RST_VAL (4'h0),
    .RISING  (1'b1)
  ) u_sync_edge (
    .clk_i  (CLK),
    .rst_ni (nRESET),
    .sig_i  (syncReq),
    .edge_o (syncRise)
  );

  // ---------------------------------------------------------------------------
  // Joypad: two-flop synchronizer, resetting to the idle (all released) value
  // so that leaving reset never looks like a key press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      joySync1_q <= IRQ_SYNC_RST;
      joySync2_q <= IRQ_SYNC_RST;
    end else begin
      joySync1_q <= nJOYP;
      joySync2_q <= joySync1_q;
    end
  end

  assign joyAllHi = &joySync2_q;

  // A key newly pressed while none were held pulls joyAllHi low; a second key
  // pressed while another is held produces no new request.
  irq_edge_detect #(
    .WIDTH   (1),
    .RST_VAL (1'b1),
    .RISING  (1'b0)
  ) u_joy_edge (
    .clk_i  (CLK),
    .rst_ni (nRESET),
    .sig_i  (joyAllHi),
    .edge_o (joyFall)
  );

  always_comb begin
    rise         = '0;
    rise[3:0]    = syncRise;
    rise[IRQ_JOYP] = joyFall;
    rise         = rise & IMPL_MASK;
  end

  // ---------------------------------------------------------------------------
  // IF next state. Order gives request > ack > CPU write, so an edge arriving
  // on the same clock as an ack or write of that bit is never lost.
  // ---------------------------------------------------------------------------
  assign regSel = MMIO_REQ & (A == IF_ADDR);

  always_comb begin
    if_d = if_q;
    if (WR && regSel) begin
      if_d = D_IN[IRQ_IF_W-1:0];
    end
    if_d = if_d & ~CPU_IRQ_ACK[IRQ_IF_W-1:0];
    if_d = if_d | rise;
    if_d = if_d & IMPL_MASK;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      if_q <= '0;
    end else begin
      if_q <= if_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Unimplemented bits never pend but read back as 1, like the
  // unused upper three bits. D_OE is gated by reset so the bus is released
  // for the whole reset period regardless of the strobes.
  // ---------------------------------------------------------------------------
  assign CPU_IRQ_TRIG = {3'b000, if_q & IMPL_MASK};
  assign D_OE         = RD & regSel & nRESET;
  assign D_OUT        = D_OE ? {3'b111, if_q | ~IMPL_MASK} : 8'h00;

`ifdef IRQ_WAKE_EN
  logic wake_q;

  // Level flag: high while any synchronized key is held, independent of IF.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wake_q <= 1'b0;
    end else begin
      wake_q <= ~joyAllHi;
    end
  end

  assign WAKE = wake_q;
`else
  assign WAKE = 1'b0;
`endif

endmodule
